mem_access: RTL and testbench

- Dual-issue MEM stage. Sits between the EX/MEM pipeline register and the MEM/WB register.
- Issues at most one load/store per cycle (slot 1 only) over an SRAM-like request/response data bus.
- Aligns and extends load data. Passes ALU results, HI/LO and write-back controls through to MEM/WB.
- Holds the pipeline through stall_req_o while a bus transaction is outstanding.

---
 rtl/mem_access.sv | 274 +++++++++++++++++++++++++++
 tb/tb_mem_access.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// MEM stage of the dual-issue pipeline. Slot 1 may carry one load or store per
// cycle over an SRAM-like request/response bus. Load data is aligned and
// extended here. Every other field passes through to MEM/WB. stall_req_o holds
// the front of the pipeline while a bus transaction is outstanding.
module mem_access #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              wb_stall_i,
   input  logic [31:0]       inst1_addr_i,
   input  logic [31:0]       inst2_addr_i,
   input  logic [4:0]        waddr1_i,
   input  logic [4:0]        waddr2_i,
   input  logic              we1_i,
   input  logic              we2_i,
   input  logic [DATA_W-1:0] wdata1_i,
   input  logic [DATA_W-1:0] wdata2_i,
   input  logic [DATA_W-1:0] hi_i,
   input  logic [DATA_W-1:0] lo_i,
   input  logic              whilo_i,
   input  logic [7:0]        aluop1_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [DATA_W-1:0] reg2_i,
   output logic [31:0]       inst1_addr_o,
   output logic [31:0]       inst2_addr_o,
   output logic [4:0]        waddr1_o,
   output logic [4:0]        waddr2_o,
   output logic              we1_o,
   output logic              we2_o,
   output logic [DATA_W-1:0] wdata1_o,
   output logic [DATA_W-1:0] wdata2_o,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o,
   output logic              whilo_o,
   output logic              stall_req_o,
   output logic              adel_o,
   output logic              ades_o,
   output logic [ADDR_W-1:0] badvaddr_o,
   output logic              data_req,
   output logic              data_wr,
   output logic [1:0]        data_size,
   output logic [ADDR_W-1:0] data_addr,
   output logic [DATA_W-1:0] data_wdata,
   input  logic              data_addr_ok,
   input  logic              data_data_ok,
   input  logic [DATA_W-1:0] data_rdata
);

   localparam logic [7:0] OP_LB  = 8'hE0;
   localparam logic [7:0] OP_LH  = 8'hE1;
   localparam logic [7:0] OP_LW  = 8'hE3;
   localparam logic [7:0] OP_LBU = 8'hE4;
   localparam logic [7:0] OP_LHU = 8'hE5;
   localparam logic [7:0] OP_SB  = 8'hE8;
   localparam logic [7:0] OP_SH  = 8'hE9;
   localparam logic [7:0] OP_SW  = 8'hEB;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_REQ    = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_DONE   = 3'd3;
   localparam logic [2:0] S_CANCEL = 3'd4;

   function automatic logic is_load(input logic [7:0] op);
      return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
             (op == OP_LHU) || (op == OP_LW);
   endfunction

   function automatic logic is_store(input logic [7:0] op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

   function automatic logic [1:0] op_size(input logic [7:0] op);
      case (op)
         OP_LB, OP_LBU, OP_SB: return 2'd0;
         OP_LH, OP_LHU, OP_SH: return 2'd1;
         default:              return 2'd2;
      endcase
   endfunction

   function automatic logic misaligned(input logic [7:0] op, input logic [1:0] off);
      case (op)
         OP_LH, OP_LHU, OP_SH: return off[0];
         OP_LW, OP_SW:         return off != 2'b00;
         default:              return 1'b0;
      endcase
   endfunction

   // Replicate store data across byte lanes so the bus can use any lane.
   function automatic logic [DATA_W-1:0] store_data(input logic [7:0] op,
                                                     input logic [DATA_W-1:0] d);
      case (op)
         OP_SB:   return {4{d[7:0]}};
         OP_SH:   return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

   // Pick the addressed little-endian lane and sign/zero extend it.
   function automatic logic [DATA_W-1:0] load_align(input logic [7:0] op,
                                                     input logic [1:0] off,
                                                     input logic [DATA_W-1:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      h = off[1] ? w[31:16] : w[15:0];
      case (op)
         OP_LB:   return {{(DATA_W-8){b[7]}}, b};
         OP_LBU:  return {{(DATA_W-8){1'b0}}, b};
         OP_LH:   return {{(DATA_W-16){h[15]}}, h};
         OP_LHU:  return {{(DATA_W-16){1'b0}}, h};
         default: return w;
      endcase
   endfunction

   logic [2:0]        state;
   logic [2:0]        state_nxt;
   logic [DATA_W-1:0] rbuf;

   // Request fields captured when the request is first raised
   logic [7:0]        req_op;
   logic [1:0]        req_off;
   logic              req_wr;
   logic [1:0]        req_size;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;

   logic              is_mem_c;
   logic              mis_c;
   logic              issue_c;
   logic              wr_c;
   logic [1:0]        size_c;
   logic [ADDR_W-1:0] addr_c;
   logic [DATA_W-1:0] wdata_c;

   // Decode slot 1 and form the bus request it would issue
   always_comb begin
      is_mem_c = is_load(aluop1_i) || is_store(aluop1_i);
      mis_c    = misaligned(aluop1_i, mem_addr_i[1:0]);
      issue_c  = (state == S_IDLE) && is_mem_c && !mis_c && !flush;
      wr_c     = is_store(aluop1_i);
      size_c   = op_size(aluop1_i);
      addr_c   = (size_c == 2'd2) ? {mem_addr_i[ADDR_W-1:2], 2'b00} : mem_addr_i;
      wdata_c  = store_data(aluop1_i, reg2_i);
   end

   // Transaction state sequencing
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (issue_c) state_nxt = data_addr_ok ? S_WAIT : S_REQ;
         S_REQ: begin
            if (data_addr_ok)  state_nxt = flush ? S_CANCEL : S_WAIT;
            else if (flush)    state_nxt = S_IDLE;
         end
         S_WAIT: begin
            if (data_data_ok)  state_nxt = flush ? S_IDLE : S_DONE;
            else if (flush)    state_nxt = S_CANCEL;
         end
         S_DONE:   if (!wb_stall_i || flush) state_nxt = S_IDLE;
         S_CANCEL: if (data_data_ok) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // State and load-buffer registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S_IDLE;
         rbuf  <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_WAIT && data_data_ok && !flush) rbuf <= data_rdata;
      end
   end

   // Hold request fields stable from first assertion until accepted
   always_ff @(posedge clk) begin
      if (issue_c) begin
         req_op    <= aluop1_i;
         req_off   <= mem_addr_i[1:0];
         req_wr    <= wr_c;
         req_size  <= size_c;
         req_addr  <= addr_c;
         req_wdata <= wdata_c;
      end
   end

   // Output steering: pass-through, exceptions, bus drive and load write-back
   always_comb begin
      inst1_addr_o = inst1_addr_i;
      inst2_addr_o = inst2_addr_i;
      waddr1_o     = waddr1_i;
      waddr2_o     = waddr2_i;
      we1_o        = we1_i;
      we2_o        = we2_i;
      wdata1_o     = wdata1_i;
      wdata2_o     = wdata2_i;
      hi_o         = hi_i;
      lo_o         = lo_i;
      whilo_o      = whilo_i;
      stall_req_o  = 1'b0;
      adel_o       = 1'b0;
      ades_o       = 1'b0;
      badvaddr_o   = '0;
      data_req     = 1'b0;
      data_wr      = (state == S_REQ) ? req_wr    : wr_c;
      data_size    = (state == S_REQ) ? req_size  : size_c;
      data_addr    = (state == S_REQ) ? req_addr  : addr_c;
      data_wdata   = (state == S_REQ) ? req_wdata : wdata_c;
      case (state)
         S_IDLE: begin
            if (is_mem_c) begin
               we1_o = 1'b0;
               if (mis_c) begin
                  adel_o     = is_load(aluop1_i);
                  ades_o     = is_store(aluop1_i);
                  badvaddr_o = mem_addr_i;
               end else begin
                  data_req    = issue_c;
                  stall_req_o = issue_c;
               end
            end
         end
         S_REQ: begin
            data_req    = 1'b1;
            stall_req_o = 1'b1;
            we1_o       = 1'b0;
         end
         S_WAIT, S_CANCEL: begin
            stall_req_o = 1'b1;
            we1_o       = 1'b0;
         end
         S_DONE: begin
            if (is_load(req_op)) wdata1_o = load_align(req_op, req_off, rbuf);
            else                 we1_o    = 1'b0;
         end
         default: begin
            we1_o = 1'b0;
         end
      endcase
      if (!rst) begin
         inst1_addr_o = '0;
         inst2_addr_o = '0;
         waddr1_o     = '0;
         waddr2_o     = '0;
         we1_o        = 1'b0;
         we2_o        = 1'b0;
         wdata1_o     = '0;
         wdata2_o     = '0;
         hi_o         = '0;
         lo_o         = '0;
         whilo_o      = 1'b0;
         stall_req_o  = 1'b0;
         adel_o       = 1'b0;
         ades_o       = 1'b0;
         badvaddr_o   = '0;
         data_req     = 1'b0;
         data_wr      = 1'b0;
         data_size    = '0;
         data_addr    = '0;
         data_wdata   = '0;
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: a vector table of single transactions plus
// hand-written sequences for delayed accept, cancel, write-back hold and reset.
module tb_mem_access;

   logic        clk = 1'b0;
   logic        rst, flush, wb_stall_i;
   logic [31:0] inst1_addr_i, inst2_addr_i;
   logic [4:0]  waddr1_i, waddr2_i;
   logic        we1_i, we2_i;
   logic [31:0] wdata1_i, wdata2_i, hi_i, lo_i;
   logic        whilo_i;
   logic [7:0]  aluop1_i;
   logic [31:0] mem_addr_i, reg2_i;
   logic [31:0] inst1_addr_o, inst2_addr_o;
   logic [4:0]  waddr1_o, waddr2_o;
   logic        we1_o, we2_o;
   logic [31:0] wdata1_o, wdata2_o, hi_o, lo_o;
   logic        whilo_o, stall_req_o, adel_o, ades_o;
   logic [31:0] badvaddr_o;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_access #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst), .flush(flush), .wb_stall_i(wb_stall_i),
      .inst1_addr_i(inst1_addr_i), .inst2_addr_i(inst2_addr_i),
      .waddr1_i(waddr1_i), .waddr2_i(waddr2_i), .we1_i(we1_i), .we2_i(we2_i),
      .wdata1_i(wdata1_i), .wdata2_i(wdata2_i), .hi_i(hi_i), .lo_i(lo_i),
      .whilo_i(whilo_i), .aluop1_i(aluop1_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
      .inst1_addr_o(inst1_addr_o), .inst2_addr_o(inst2_addr_o),
      .waddr1_o(waddr1_o), .waddr2_o(waddr2_o), .we1_o(we1_o), .we2_o(we2_o),
      .wdata1_o(wdata1_o), .wdata2_o(wdata2_o), .hi_o(hi_o), .lo_o(lo_o),
      .whilo_o(whilo_o), .stall_req_o(stall_req_o), .adel_o(adel_o), .ades_o(ades_o),
      .badvaddr_o(badvaddr_o), .data_req(data_req), .data_wr(data_wr),
      .data_size(data_size), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
   );

   typedef struct {
      logic [7:0]  op;
      logic [31:0] addr;
      logic [31:0] reg2;
      logic [31:0] rdata;
      logic        req;
      logic        wr;
      logic [1:0]  size;
      logic [31:0] baddr;
      logic [31:0] bwdata;
      logic        chk_wd;
      logic [31:0] wd;
      logic        we1;
      logic        adel;
      logic        ades;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic go_quiet();
      aluop1_i     = 8'h00;
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      flush        = 1'b0;
      wb_stall_i   = 1'b0;
   endtask

   function automatic vec_t mk(input logic [7:0] op, input logic [31:0] addr,
                               input logic [31:0] reg2, input logic [31:0] rdata,
                               input logic req, input logic wr, input logic [1:0] size,
                               input logic [31:0] baddr, input logic [31:0] bwdata,
                               input logic chk_wd, input logic [31:0] wd,
                               input logic we1, input logic adel, input logic ades);
      vec_t v;
      v.op = op; v.addr = addr; v.reg2 = reg2; v.rdata = rdata;
      v.req = req; v.wr = wr; v.size = size; v.baddr = baddr; v.bwdata = bwdata;
      v.chk_wd = chk_wd; v.wd = wd; v.we1 = we1; v.adel = adel; v.ades = ades;
      return v;
   endfunction

   task automatic run_vec(input int i);
      vec_t v;
      v = vecs[i];
      aluop1_i = v.op; mem_addr_i = v.addr; reg2_i = v.reg2;
      we1_i = 1'b1; wdata1_i = 32'h5555_AAAA;
      data_addr_ok = 1'b1; data_data_ok = 1'b0;
      #2;
      chk($sformatf("v%0d data_req", i), data_req, v.req);
      chk($sformatf("v%0d adel", i), adel_o, v.adel);
      chk($sformatf("v%0d ades", i), ades_o, v.ades);
      if (v.adel || v.ades) chk($sformatf("v%0d badvaddr", i), badvaddr_o, v.addr);
      if (v.req) begin
         chk($sformatf("v%0d size", i), data_size, v.size);
         chk($sformatf("v%0d addr", i), data_addr, v.baddr);
         chk($sformatf("v%0d wr", i), data_wr, v.wr);
         if (v.wr) chk($sformatf("v%0d wdata", i), data_wdata, v.bwdata);
         chk($sformatf("v%0d stall issue", i), stall_req_o, 1'b1);
         tick();
         data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = v.rdata;
         #2;
         chk($sformatf("v%0d stall wait", i), stall_req_o, 1'b1);
         tick();
         data_data_ok = 1'b0; data_rdata = 32'h0;
         #2;
         chk($sformatf("v%0d stall done", i), stall_req_o, 1'b0);
      end else begin
         chk($sformatf("v%0d stall", i), stall_req_o, 1'b0);
      end
      chk($sformatf("v%0d we1", i), we1_o, v.we1);
      if (v.chk_wd) chk($sformatf("v%0d wdata1", i), wdata1_o, v.wd);
      tick();
      go_quiet();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int hs;
      int reqs;
      //             op     addr          reg2          rdata         req wr sz baddr        bwdata        cw wd            we1 el es
      vecs[0]  = mk(8'hE0, 32'h8000_0003, 32'h0,        32'h80FF_0012, 1, 0, 0, 32'h8000_0003, 32'h0,        1, 32'hFFFF_FF80, 1, 0, 0);
      vecs[1]  = mk(8'hE4, 32'h8000_0003, 32'h0,        32'h80FF_0012, 1, 0, 0, 32'h8000_0003, 32'h0,        1, 32'h0000_0080, 1, 0, 0);
      vecs[2]  = mk(8'hE1, 32'h8000_0002, 32'h0,        32'h80FF_0012, 1, 0, 1, 32'h8000_0002, 32'h0,        1, 32'hFFFF_80FF, 1, 0, 0);
      vecs[3]  = mk(8'hE5, 32'h8000_0002, 32'h0,        32'h80FF_0012, 1, 0, 1, 32'h8000_0002, 32'h0,        1, 32'h0000_80FF, 1, 0, 0);
      vecs[4]  = mk(8'hE0, 32'h8000_0000, 32'h0,        32'h80FF_0092, 1, 0, 0, 32'h8000_0000, 32'h0,        1, 32'hFFFF_FF92, 1, 0, 0);
      vecs[5]  = mk(8'hE1, 32'h8000_0000, 32'h0,        32'h80FF_0012, 1, 0, 1, 32'h8000_0000, 32'h0,        1, 32'h0000_0012, 1, 0, 0);
      vecs[6]  = mk(8'hE3, 32'h8000_1004, 32'h0,        32'hDEAD_BEEF, 1, 0, 2, 32'h8000_1004, 32'h0,        1, 32'hDEAD_BEEF, 1, 0, 0);
      vecs[7]  = mk(8'hE8, 32'h1000_0001, 32'h1234_ABCD, 32'h0,        1, 1, 0, 32'h1000_0001, 32'hCDCD_CDCD, 0, 32'h0,        0, 0, 0);
      vecs[8]  = mk(8'hEB, 32'h1000_0008, 32'h1234_ABCD, 32'h0,        1, 1, 2, 32'h1000_0008, 32'h1234_ABCD, 0, 32'h0,        0, 0, 0);
      vecs[9]  = mk(8'hE3, 32'h8000_0006, 32'h0,        32'h0,        0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 1, 0);
      vecs[10] = mk(8'hEB, 32'h8000_0001, 32'h0,        32'h0,        0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 1);
      vecs[11] = mk(8'hE1, 32'h8000_0011, 32'h0,        32'h0,        0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 1, 0);
      vecs[12] = mk(8'hE9, 32'h8000_0013, 32'h0,        32'h0,        0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 1);
      vecs[13] = mk(8'h21, 32'h8000_0003, 32'h0,        32'h0,        0, 0, 0, 32'h0,        32'h0,        1, 32'h5555_AAAA, 1, 0, 0);

      rst = 1'b0; flush = 1'b0; wb_stall_i = 1'b0;
      inst1_addr_i = 32'hBFC0_0000; inst2_addr_i = 32'hBFC0_0004;
      waddr1_i = 5'd3; waddr2_i = 5'd4; we1_i = 1'b1; we2_i = 1'b1;
      wdata1_i = 32'h5555_AAAA; wdata2_i = 32'h6666_7777;
      hi_i = 32'h1111_1111; lo_i = 32'h2222_2222; whilo_i = 1'b1;
      aluop1_i = 8'hE3; mem_addr_i = 32'h8000_0000; reg2_i = 32'h0;
      data_addr_ok = 1'b1; data_data_ok = 1'b0; data_rdata = 32'h0;
      tick(); tick();
      #2;
      chk("reset we1", we1_o, 1'b0);
      chk("reset we2", we2_o, 1'b0);
      chk("reset whilo", whilo_o, 1'b0);
      chk("reset data_req", data_req, 1'b0);
      chk("reset stall", stall_req_o, 1'b0);
      chk("reset wdata1", wdata1_o, 32'h0);
      rst = 1'b1;
      go_quiet();
      #1;
      chk("slot2 wdata pass", wdata2_o, 32'h6666_7777);
      chk("hi pass", hi_o, 32'h1111_1111);
      tick();

      for (int i = 0; i < 14; i++) run_vec(i);

      // LW accepted at once, response three cycles later
      hs = 0;
      aluop1_i = 8'hE3; mem_addr_i = 32'h8000_1004; we1_i = 1'b1;
      data_addr_ok = 1'b1; #2;
      chk("lw c0 stall", stall_req_o, 1'b1);
      chk("lw c0 req", data_req, 1'b1);
      hs += int'(data_req & data_addr_ok);
      tick(); data_addr_ok = 1'b0; #2;
      chk("lw c1 stall", stall_req_o, 1'b1);
      hs += int'(data_req & data_addr_ok);
      tick(); #2;
      chk("lw c2 stall", stall_req_o, 1'b1);
      chk("lw c2 req", data_req, 1'b0);
      tick(); data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF; #2;
      chk("lw c3 stall", stall_req_o, 1'b1);
      tick(); data_data_ok = 1'b0; data_rdata = 32'h0; #2;
      chk("lw c4 stall", stall_req_o, 1'b0);
      chk("lw c4 wdata1", wdata1_o, 32'hDEAD_BEEF);
      chk("lw c4 we1", we1_o, 1'b1);
      hs += int'(data_req & data_addr_ok);
      tick(); go_quiet(); #2;
      chk("lw handshakes", hs, 1);

      // SH with accept delayed two cycles; store data changes while waiting
      reqs = 0;
      aluop1_i = 8'hE9; mem_addr_i = 32'h0000_0010; reg2_i = 32'h1234_ABCD;
      data_addr_ok = 1'b0; #2;
      reqs += int'(data_req);
      chk("sh c0 wdata", data_wdata, 32'hABCD_ABCD);
      tick(); reg2_i = 32'h0; #2;
      reqs += int'(data_req);
      chk("sh c1 size", data_size, 2'd1);
      chk("sh c1 wdata held", data_wdata, 32'hABCD_ABCD);
      chk("sh c1 wr", data_wr, 1'b1);
      chk("sh c1 addr", data_addr, 32'h0000_0010);
      tick(); data_addr_ok = 1'b1; #2;
      reqs += int'(data_req);
      chk("sh c2 wdata", data_wdata, 32'hABCD_ABCD);
      tick(); data_addr_ok = 1'b0; data_data_ok = 1'b1; #2;
      reqs += int'(data_req);
      chk("sh c3 stall", stall_req_o, 1'b1);
      tick(); data_data_ok = 1'b0; #2;
      chk("sh done we1", we1_o, 1'b0);
      chk("sh done stall", stall_req_o, 1'b0);
      chk("sh req cycles", reqs, 3);
      tick(); go_quiet();

      // Flush while waiting: cancel, absorb the late response, then reissue
      aluop1_i = 8'hE3; mem_addr_i = 32'h8000_0300; data_addr_ok = 1'b1; #2;
      tick(); data_addr_ok = 1'b0; flush = 1'b1; #2;
      chk("cancel c1 stall", stall_req_o, 1'b1);
      tick(); flush = 1'b0; #2;
      chk("cancel c2 stall", stall_req_o, 1'b1);
      chk("cancel c2 we1", we1_o, 1'b0);
      chk("cancel c2 req", data_req, 1'b0);
      tick(); data_data_ok = 1'b1; data_rdata = 32'hAAAA_AAAA; #2;
      chk("cancel c3 stall", stall_req_o, 1'b1);
      chk("cancel c3 we1", we1_o, 1'b0);
      tick(); data_data_ok = 1'b0; mem_addr_i = 32'h8000_0304; data_addr_ok = 1'b1; #2;
      chk("reissue req", data_req, 1'b1);
      chk("reissue addr", data_addr, 32'h8000_0304);
      tick(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0102_0304; #2;
      tick(); data_data_ok = 1'b0; data_rdata = 32'h0; #2;
      chk("reissue wdata1", wdata1_o, 32'h0102_0304);
      chk("reissue we1", we1_o, 1'b1);
      tick(); go_quiet();

      // Completion while MEM/WB holds: stay in DONE, no second request
      aluop1_i = 8'hE3; mem_addr_i = 32'h8000_0100; data_addr_ok = 1'b1; #2;
      tick(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
      wb_stall_i = 1'b1; #2;
      for (int c = 0; c < 3; c++) begin
         tick(); data_data_ok = 1'b0; data_rdata = 32'hFFFF_FFFF; data_addr_ok = 1'b1; #2;
         chk($sformatf("hold c%0d wdata1", c), wdata1_o, 32'h1234_5678);
         chk($sformatf("hold c%0d req", c), data_req, 1'b0);
         chk($sformatf("hold c%0d stall", c), stall_req_o, 1'b0);
      end
      tick(); wb_stall_i = 1'b0; data_addr_ok = 1'b0; #2;
      chk("hold release wdata1", wdata1_o, 32'h1234_5678);
      chk("hold release req", data_req, 1'b0);
      tick(); go_quiet();

      // Reset arriving while a request waits for acceptance
      aluop1_i = 8'hE3; mem_addr_i = 32'h8000_0200; data_addr_ok = 1'b0; #2;
      chk("rreq c0 req", data_req, 1'b1);
      tick(); #2;
      chk("rreq c1 req", data_req, 1'b1);
      rst = 1'b0; #1;
      chk("rreq in reset req", data_req, 1'b0);
      chk("rreq in reset stall", stall_req_o, 1'b0);
      tick(); rst = 1'b1; aluop1_i = 8'h00; #2;
      chk("rreq after req", data_req, 1'b0);
      chk("rreq after stall", stall_req_o, 1'b0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
